// File: rtl/wb_word_serializer.sv
// Observer tap: captures accepted 128-bit line writes and replays them as one-cycle word strobes.
// Optional build macro WB_TAP_PORT_FILTER_EN restricts replay to words whose address equals TEST_PORT.
module wb_word_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [29:0] TEST_PORT = 30'h3FF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_write,
  input  logic         mem_ready,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [29:0]  addr,
  output logic [31:0]  data,
  output logic         wen,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t state_reg, state_next;

  logic [3:0]   cap_mask;
  logic         push, pop, advance, accept, drop;
  logic         fifo_full, fifo_empty;

  logic [27:0]  fifo_addr_mem [DEPTH];
  logic [127:0] fifo_data_mem [DEPTH];
  logic [3:0]   fifo_mask_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    drop_cnt_reg;

  logic [27:0]  head_addr;
  logic [127:0] head_data;
  logic [3:0]   head_mask;
  logic [1:0]   head_idx;

  logic [27:0]  line_addr_reg;
  logic [127:0] line_data_reg;
  logic [3:0]   line_mask_reg;
  logic [1:0]   word_idx_reg;
  logic [3:0]   remaining;
  logic         more_words;
  logic [1:0]   next_idx;

  logic [29:0]  addr_reg;
  logic [31:0]  data_reg;

  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] k);
    return d[{k, 5'b0} +: 32];
  endfunction

  // Per-word selection mask, fixed at capture time and stored alongside the line.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
`ifdef WB_TAP_PORT_FILTER_EN
      assign cap_mask[gi] = ({mem_addr, 2'(gi)} == TEST_PORT);
`else
      assign cap_mask[gi] = 1'b1;
`endif
    end
  endgenerate

`ifndef WB_TAP_PORT_FILTER_EN
  logic unused_test_port;
  assign unused_test_port = ^TEST_PORT;
`endif

  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);

  // A full FIFO still takes the new line when the head leaves on the same edge.
  assign push   = mem_write && mem_ready && (|cap_mask);
  assign accept = push && (!fifo_full || pop);
  assign drop   = push && fifo_full && !pop;

  assign head_addr = fifo_addr_mem[rd_ptr_reg];
  assign head_data = fifo_data_mem[rd_ptr_reg];
  assign head_mask = fifo_mask_mem[rd_ptr_reg];
  assign head_idx  = first_set(head_mask);

  assign remaining  = line_mask_reg & (4'b1110 << word_idx_reg);
  assign more_words = |remaining;
  assign next_idx   = first_set(remaining);

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_addr_mem[wr_ptr_reg] <= mem_addr;
      fifo_data_mem[wr_ptr_reg] <= mem_wdata;
      fifo_mask_mem[wr_ptr_reg] <= cap_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (accept && !pop)      count_reg <= count_reg + CW'(1);
      else if (!accept && pop) count_reg <= count_reg - CW'(1);
      if (drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: state_next = GAP;
      GAP: begin
        if (more_words) begin
          advance    = 1'b1;
          state_next = WRITE;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_addr_reg <= '0;
      line_data_reg <= '0;
      line_mask_reg <= '0;
      word_idx_reg  <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
    end else if (pop) begin
      line_addr_reg <= head_addr;
      line_data_reg <= head_data;
      line_mask_reg <= head_mask;
      word_idx_reg  <= head_idx;
      addr_reg      <= {head_addr, head_idx};
      data_reg      <= word_of(head_data, head_idx);
    end else if (advance) begin
      word_idx_reg  <= next_idx;
      addr_reg      <= {line_addr_reg, next_idx};
      data_reg      <= word_of(line_data_reg, next_idx);
    end
  end

  assign wen      = (state_reg == WRITE);
  assign busy     = !fifo_empty || (state_reg != IDLE);
  assign addr     = addr_reg;
  assign data     = data_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_wb_word_serializer.sv
// Bench for wb_word_serializer: queue-based reference model checked every cycle, plus literal scenario checks.
module tb_wb_word_serializer;

  localparam int          DEPTH     = 4;
  localparam logic [29:0] TEST_PORT = 30'h3FF;
`ifdef WB_TAP_PORT_FILTER_EN
  localparam int KLO       = 3;
  localparam int OVF_LINES = 6;
  localparam int OVF_DROP  = 0;
`else
  localparam int KLO       = 0;
  localparam int OVF_LINES = 5;
  localparam int OVF_DROP  = 1;
`endif
  localparam int WPL = 4 - KLO;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mem_write = 1'b0;
  logic         mem_ready = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [29:0]  addr;
  logic [31:0]  data;
  logic         wen;
  logic         busy;
  logic [7:0]   drop_cnt;

  wb_word_serializer #(.DEPTH(DEPTH), .TEST_PORT(TEST_PORT)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .addr(addr), .data(data),
    .wen(wen), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: queued lines, a word list for the line in flight, one word every 2 cycles.
  typedef struct packed {
    logic [27:0]  a;
    logic [127:0] d;
    logic [3:0]   m;
  } line_t;

  line_t       line_q[$];
  logic [61:0] word_q[$];
  line_t       m_ln;
  logic [61:0] m_w;
  logic [3:0]  m_mask;
  int          mcyc      = 0;
  int          next_slot = 0;
  logic        exp_wen   = 1'b0;
  logic        exp_busy  = 1'b0;
  logic [29:0] exp_addr  = '0;
  logic [31:0] exp_data  = '0;
  logic [7:0]  exp_drop  = '0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      line_q.delete();
      word_q.delete();
      next_slot = 0;
      exp_wen   = 1'b0;
      exp_busy  = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_drop  = '0;
    end else begin
      mcyc++;
      exp_wen = 1'b0;
      if (mcyc >= next_slot) begin
        if (word_q.size() == 0 && line_q.size() > 0) begin
          m_ln = line_q.pop_front();
          for (int k = 0; k < 4; k++)
            if (m_ln.m[k]) word_q.push_back({m_ln.a, 2'(k), m_ln.d[32*k +: 32]});
        end
        if (word_q.size() > 0) begin
          m_w       = word_q.pop_front();
          exp_wen   = 1'b1;
          exp_addr  = m_w[61:32];
          exp_data  = m_w[31:0];
          next_slot = mcyc + 2;
        end
      end
      if (mem_write && mem_ready) begin
`ifdef WB_TAP_PORT_FILTER_EN
        for (int k = 0; k < 4; k++) m_mask[k] = ({mem_addr, 2'(k)} == TEST_PORT);
`else
        m_mask = 4'hF;
`endif
        if (m_mask != 4'h0) begin
          if (line_q.size() < DEPTH) line_q.push_back({mem_addr, mem_wdata, m_mask});
          else if (exp_drop != 8'hFF) exp_drop++;
        end
      end
      exp_busy = (line_q.size() > 0) || (word_q.size() > 0) || (mcyc < next_slot);
    end
  end

  typedef struct {
    int          c;
    logic [29:0] a;
    logic [31:0] d;
  } pulse_t;

  pulse_t plog[$];
  int     busy_fall = -1;
  logic   prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    chk("wen",      64'(wen),      64'(exp_wen));
    chk("busy",     64'(busy),     64'(exp_busy));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("addr",     64'(addr),     64'(exp_addr));
    chk("data",     64'(data),     64'(exp_data));
    if (wen === 1'b1) plog.push_back('{cyc, addr, data});
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [27:0] a, input logic [127:0] d);
    mem_write = 1'b1;
    mem_ready = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
  endtask

  task automatic quiet();
    mem_write = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    repeat (2) tick();
    chk("drain_idle", 64'(busy), 64'(0));
  endtask

  function automatic logic [127:0] mkline(input int tag);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'(tag * 256 + k);
    return r;
  endfunction

  // Expected pulses for lines at 28'h0FF tagged tag0.. captured from edge e onward.
  task automatic chk_lines(input string nm, input int e, input int nlines, input int tag0);
    int j;
    j = 0;
    chk({nm, "_count"}, 64'(plog.size()), 64'(nlines * WPL));
    for (int i = 0; i < nlines; i++) begin
      for (int k = KLO; k < 4; k++) begin
        if (j < plog.size()) begin
          chk({nm, "_cycle"}, 64'(plog[j].c), 64'(e + 1 + 2 * j));
          chk({nm, "_addr"},  64'(plog[j].a), 64'({28'h0FF, 2'(k)}));
          chk({nm, "_data"},  64'(plog[j].d), 64'((tag0 + i) * 256 + k));
        end
        j++;
      end
    end
  endtask

  logic [31:0] t1_dat [4];
  int          e;
  logic        found;
  int          r;

  initial begin
    t1_dat = '{32'h0, 32'h1, 32'h2, 32'h168};
    repeat (3) tick();
    chk("rst_wen",  64'(wen),      64'(0));
    chk("rst_busy", 64'(busy),     64'(0));
    chk("rst_addr", 64'(addr),     64'(0));
    chk("rst_data", 64'(data),     64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    #2 rst = 1'b1;
    tick();

    // single line
    plog.delete();
    e = cyc + 1;
    cap(28'h0FF, {32'h168, 32'h2, 32'h1, 32'h0});
    quiet();
    drain();
    chk("t1_count", 64'(plog.size()), 64'(WPL));
    for (int j = 0; j < WPL && j < plog.size(); j++) begin
      chk("t1_cycle", 64'(plog[j].c), 64'(e + 1 + 2 * j));
      chk("t1_addr",  64'(plog[j].a), 64'({28'h0FF, 2'(KLO + j)}));
      chk("t1_data",  64'(plog[j].d), 64'(t1_dat[KLO + j]));
    end
    chk("t1_busy_fall", 64'(busy_fall), 64'(e + 1 + 2 * WPL));

    // back-to-back lines
    plog.delete();
    e = cyc + 1;
    for (int i = 0; i < 3; i++) cap(28'h0FF, mkline(1 + i));
    quiet();
    drain();
    chk_lines("t2", e, 3, 1);
    chk("t2_drop", 64'(drop_cnt), 64'(0));

    // handshake: only the edge with mem_ready captures
    plog.delete();
    mem_write = 1'b1;
    mem_ready = 1'b0;
    mem_addr  = 28'h0FF;
    mem_wdata = mkline(9);
    tick();
    tick();
    mem_ready = 1'b1;
    e = cyc + 1;
    tick();
    quiet();
    drain();
    chk_lines("t4", e, 1, 9);

    // overflow
    plog.delete();
    e = cyc + 1;
    for (int i = 0; i < 6; i++) cap(28'h0FF, mkline(16 + i));
    quiet();
    drain();
    chk_lines("t3", e, OVF_LINES, 16);
    chk("t3_drop", 64'(drop_cnt), 64'(OVF_DROP));

`ifdef WB_TAP_PORT_FILTER_EN
    plog.delete();
    e = cyc + 1;
    cap(28'h0FE, mkline(32));
    cap(28'h0FF, {32'hD5D, 32'h3, 32'h2, 32'h1});
    quiet();
    drain();
    chk("t6_count", 64'(plog.size()), 64'(1));
    if (plog.size() > 0) begin
      chk("t6_addr",  64'(plog[0].a), 64'(30'h3FF));
      chk("t6_data",  64'(plog[0].d), 64'(32'hD5D));
      chk("t6_cycle", 64'(plog[0].c), 64'(e + 2));
    end
`endif

    // reset mid-line with lines queued
    for (int i = 0; i < 3; i++) cap(28'h0FF, mkline(48 + i));
    quiet();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wen && addr[1:0] == ((KLO == 3) ? 2'd3 : 2'd1)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t5_reach_word", 64'(found), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("t5_async_wen",  64'(wen),      64'(0));
    chk("t5_async_busy", 64'(busy),     64'(0));
    chk("t5_async_drop", 64'(drop_cnt), 64'(0));
    chk("t5_async_addr", 64'(addr),     64'(0));
    chk("t5_async_data", 64'(data),     64'(0));
    tick();
    tick();
    #3 rst = 1'b1;
    plog.delete();
    repeat (20) tick();
    chk("t5_no_pulses", 64'(plog.size()), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));

    // sustained overflow saturates the drop counter
    for (int i = 0; i < 600; i++) cap(28'h0FF, {$urandom, $urandom, $urandom, $urandom});
    quiet();
    drain();
    chk("sat_drop", 64'(drop_cnt), 64'(255));

    // randomized traffic, checked cycle by cycle against the model
    #2 rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      mem_write = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0:       mem_addr = 28'h0FF;
        1:       mem_addr = 28'h0FE;
        default: mem_addr = 28'($urandom);
      endcase
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    quiet();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_word_serializer.md
# wb_word_serializer

- Bus tap on the L1-to-memory write interface of the L2-cache build.
- Captures each accepted 128-bit line write and replays it as a word-granular stream on `addr`/`data`/`wen`.
- `wen` returns low between words, so downstream checkers see one rising edge per word.
- Feeds the result-checking testbed. It is purely an observer and never back-pressures memory traffic.

## Interface

**Parameters**
- `DEPTH`, default 4: line FIFO depth. Power of two, ≥2.
- `TEST_PORT`, default 30'h3FF: word address passed by the filter (see Configuration).

**Ports**
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mem_write` input 1: memory write request, observed only.
- `mem_ready` input 1: memory completion strobe, observed only.
- `mem_addr` input 28: line address.
- `mem_wdata` input 128: line data. Word k = `mem_wdata[32k+31:32k]`.
- `addr` output 30: word address `{line_addr, k[1:0]}`.
- `data` output 32: word data.
- `wen` output 1: word write strobe, high for exactly 1 cycle per word.
- `busy` output 1: FIFO non-empty or state ≠ IDLE.
- `drop_cnt` output 8: lines lost to overflow, saturating at 255.

## Operation

**Capture**
- A line is accepted on an edge where `mem_write && mem_ready`. One capture per such edge.
- `mem_write` held without `mem_ready` captures nothing.
- The accepted `{mem_addr, mem_wdata}` is pushed into the FIFO.

**FSM states: IDLE, WRITE, GAP**
- IDLE→WRITE when FIFO non-empty. Pop the head into the line register and start at word 0.
- WRITE→GAP always.
- GAP→WRITE with the next word when words remain in the current line.
- GAP→WRITE with a pop of a new line at word 0 when the line is done and the FIFO is non-empty.
- GAP→IDLE when the line is done and the FIFO is empty.

**Outputs**
- `wen` = (state == WRITE).
- `addr`/`data` are registered and hold the current word through WRITE and GAP.

**FIFO**
- Push and pop on the same edge are always legal, including when the FIFO is full. The push is accepted.
- A push when full with no pop on that edge: the line is dropped, FIFO contents are unchanged, and `drop_cnt` increments (saturating).
- Pointers wrap modulo `DEPTH`. The count is kept in clog2(`DEPTH`)+1 bits.

**Reset**
- All outputs reset to 0: `addr`, `data`, `wen`, `busy`, `drop_cnt`.
- State goes to IDLE, the FIFO is emptied and the line register is cleared.
- Reset asserted mid-line aborts immediately. No residual words are emitted after release.

## Timing

- Latency: capture edge E → pop at E+1 → `wen` high in the cycle E+1..E+2.
- One word per 2 cycles. One unfiltered line takes 8 cycles.
- Back-to-back lines have no idle cycle: the next line's word 0 follows the previous GAP directly.
- Sustained input faster than 1 line per 8 cycles fills the FIFO. Overflow is counted, never stalled.

## Configuration

**`WB_TAP_PORT_FILTER_EN`**

Defined:
- At push, compute a 4-bit mask of words whose address == `TEST_PORT`.
- A line with an all-zero mask is not pushed. It counts as neither captured nor dropped.
- Only masked words are emitted, in ascending k. WRITE/GAP sequencing skips unmasked words with no cycle cost.

Undefined:
- The mask is forced to 4'b1111. All lines are pushed and all 4 words are emitted.

## Test plan

1. **Single line (unfiltered)**
   - Stimulus: capture `mem_addr`=28'h0FF, words 0..3 = 0,1,2,32'h168.
   - Required: `wen` pattern 1,0,1,0,1,0,1,0 starting at the cycle after E+1.
   - Required: `addr` 3FC,3FD,3FE,3FF with matching data.
   - Required: `busy` falls after the 8th cycle.
2. **Back-to-back lines**
   - Stimulus: 3 captures on consecutive edges.
   - Required: 12 `wen` pulses spaced exactly 2 cycles apart, in capture order, `drop_cnt`=0.
3. **Overflow (DEPTH=4)**
   - Stimulus: captures on 6 consecutive edges E0..E5.
   - Required: lines from E0..E4 are emitted (20 pulses); the E5 line is dropped; `drop_cnt`=1.
4. **Handshake**
   - Stimulus: `mem_write` high 3 cycles, `mem_ready` high only in the 3rd.
   - Required: exactly one line is replayed.
5. **Reset mid-line**
   - Stimulus: drop `rst` during WRITE of word 1 with 2 lines queued.
   - Required: `wen`/`busy`/`drop_cnt` go to 0 asynchronously.
   - Required: no `wen` pulses in the 20 cycles after release.
6. **Filter (`WB_TAP_PORT_FILTER_EN`)**
   - Stimulus: lines 28'h0FE and 28'h0FF, with word 3 of line 28'h0FF = 32'hD5D.
   - Required: a single `wen` pulse with `addr`=30'h3FF, `data`=32'hD5D.
   - Required: line 28'h0FE is never pushed.
